// File: rtl/lcd_scroll_buffer_if.sv
// Host-side bus of the LCD scroll buffer: character strobes and controls in,
// registered display window and buffer status out.
interface lcd_scroll_buffer_if #(
    parameter int CHAR_W = 8,
    parameter int DEPTH  = 8,
    parameter int WIN    = 4
);
    logic [CHAR_W-1:0]          char_in;
    logic                       show;
    logic                       clear;
    logic                       scroll_en;
    logic [WIN*CHAR_W-1:0]      display;
    logic [$clog2(DEPTH+1)-1:0] char_count;
    logic                       full;
    logic [$clog2(DEPTH)-1:0]   scroll_pos;

    modport master (
        output char_in, show, clear, scroll_en,
        input  display, char_count, full, scroll_pos
    );

    modport slave (
        input  char_in, show, clear, scroll_en,
        output display, char_count, full, scroll_pos
    );
endinterface

// File: rtl/lcd_scroll_buffer.sv
// Character buffer feeding a registered, optionally rotating WIN-character LCD window.
// Latency: a stored character or a scroll step shows on display one edge later.
// No backpressure: show is always taken; when full the char is dropped or the oldest is shifted out.
module lcd_scroll_buffer #(
    parameter int                CHAR_W     = 8,
    parameter int                DEPTH      = 8,
    parameter int                WIN        = 4,
    parameter int                SCROLL_DIV = 3,
    parameter int                OVERWRITE  = 0,
    parameter logic [CHAR_W-1:0] BLANK      = 'h20
) (
    input  logic              clk,
    input  logic              rst,
    lcd_scroll_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DIV_W = $clog2(SCROLL_DIV + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] POS_LAST = PTR_W'(DEPTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
    localparam logic [PTR_W:0]   WRAP     = (PTR_W + 1)'(DEPTH);

    logic [CHAR_W-1:0]     mem [DEPTH];
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      pos;
    logic [DIV_W-1:0]      div;
    logic [WIN*CHAR_W-1:0] disp;
    logic [WIN*CHAR_W-1:0] disp_next;
    logic [PTR_W:0]        idx [WIN];
    logic                  full;

    assign full           = (count == CNT_MAX);
    assign bus.full       = full;
    assign bus.char_count = count;
    assign bus.scroll_pos = pos;
    assign bus.display    = disp;

    // Buffer contents and fill level; clear wins over show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= BLANK;
            count <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= BLANK;
            count <= '0;
        end else if (bus.show) begin
            if (!full) begin
                mem[count[PTR_W-1:0]] <= bus.char_in;
                count                 <= count + CNT_W'(1);
            end else if (OVERWRITE != 0) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
                mem[DEPTH-1] <= bus.char_in;
            end
        end
    end

    // Scroll divider and window origin; dropping scroll_en snaps back to slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
            div <= '0;
        end else if (bus.clear || !bus.scroll_en) begin
            pos <= '0;
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            pos <= (pos == POS_LAST) ? '0 : pos + PTR_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // pos < DEPTH and k < DEPTH, so one conditional subtract replaces a modulo.
    always_comb begin
        disp_next = '0;
        for (int k = 0; k < WIN; k++) begin
            idx[k] = {1'b0, pos} + (PTR_W + 1)'(k);
            if (idx[k] >= WRAP) idx[k] = idx[k] - WRAP;
            disp_next[(WIN-1-k)*CHAR_W +: CHAR_W] = mem[idx[k][PTR_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) disp <= {WIN{BLANK}};
        else     disp <= disp_next;
    end
endmodule

// File: tb/tb_lcd_scroll_buffer.sv
// Bench for lcd_scroll_buffer: two instances (drop / overwrite when full) on shared stimulus.
module tb_lcd_scroll_buffer;
    localparam int          CHAR_W     = 8;
    localparam int          DEPTH      = 8;
    localparam int          WIN        = 4;
    localparam int          SCROLL_DIV = 3;
    localparam logic [31:0] ALL_BLANK  = 32'h20202020;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in;
    logic       show;
    logic       clear;
    logic       scroll_en;
    int         checks = 0;
    int         errors = 0;

    lcd_scroll_buffer_if #(.CHAR_W(CHAR_W), .DEPTH(DEPTH), .WIN(WIN)) if0 ();
    lcd_scroll_buffer_if #(.CHAR_W(CHAR_W), .DEPTH(DEPTH), .WIN(WIN)) if1 ();

    assign if0.char_in   = char_in;
    assign if0.show      = show;
    assign if0.clear     = clear;
    assign if0.scroll_en = scroll_en;
    assign if1.char_in   = char_in;
    assign if1.show      = show;
    assign if1.clear     = clear;
    assign if1.scroll_en = scroll_en;

    lcd_scroll_buffer #(.CHAR_W(CHAR_W), .DEPTH(DEPTH), .WIN(WIN), .SCROLL_DIV(SCROLL_DIV),
                        .OVERWRITE(0), .BLANK(8'h20))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    lcd_scroll_buffer #(.CHAR_W(CHAR_W), .DEPTH(DEPTH), .WIN(WIN), .SCROLL_DIV(SCROLL_DIV),
                        .OVERWRITE(1), .BLANK(8'h20))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    // Reference model: stored text as queues (oldest first), scroll as a run length.
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    int          run;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;

    function automatic int model_pos();
        return (run / SCROLL_DIV) % DEPTH;
    endfunction

    function automatic logic [31:0] window(input bit which);
        logic [31:0] r = '0;
        logic [7:0]  c;
        int          p;
        for (int k = 0; k < WIN; k++) begin
            p = (model_pos() + k) % DEPTH;
            if (which) c = (p < q1.size()) ? q1[p] : 8'h20;
            else       c = (p < q0.size()) ? q0[p] : 8'h20;
            r = {r[23:0], c};
        end
        return r;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        run    = 0;
        exp_d0 = ALL_BLANK;
        exp_d1 = ALL_BLANK;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then settle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            exp_d0 = window(1'b0);
            exp_d1 = window(1'b1);
            if (clear) begin
                q0.delete();
                q1.delete();
                run = 0;
            end else begin
                if (show) begin
                    if (q0.size() < DEPTH) q0.push_back(char_in);
                    if (q1.size() >= DEPTH) void'(q1.pop_front());
                    q1.push_back(char_in);
                end
                run = scroll_en ? run + 1 : 0;
            end
        end
        #1;
    endtask

    task automatic put(input logic [7:0] c);
        show    = 1'b1;
        char_in = c;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; show = 1'b0; clear = 1'b0; scroll_en = 1'b0; char_in = 8'h00;
        model_reset();
        repeat (2) tick();
        checks++; if (if0.display !== ALL_BLANK) begin errors++; $display("FAIL reset_display0: got %h expected %h", if0.display, ALL_BLANK); end
        checks++; if (if1.display !== ALL_BLANK) begin errors++; $display("FAIL reset_display1: got %h expected %h", if1.display, ALL_BLANK); end
        checks++; if (if0.char_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", if0.char_count); end
        checks++; if (if0.full !== 1'b0 || if1.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b/%b expected 0/0", if0.full, if1.full); end
        checks++; if (if0.scroll_pos !== 3'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", if0.scroll_pos); end
        rst = 1'b0;
        // Build up state mid-scroll, then hit reset between clock edges.
        scroll_en = 1'b1;
        for (int i = 0; i < 6; i++) put(8'(8'h61 + i));
        show = 1'b0;
        repeat (4) tick();
        checks++; if (if0.scroll_pos !== 3'(model_pos())) begin errors++; $display("FAIL premid_pos: got %0d expected %0d", if0.scroll_pos, model_pos()); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (if0.display !== ALL_BLANK || if1.display !== ALL_BLANK) begin errors++; $display("FAIL midreset_display: got %h/%h expected %h", if0.display, if1.display, ALL_BLANK); end
        checks++; if (if0.char_count !== 4'd0 || if1.char_count !== 4'd0) begin errors++; $display("FAIL midreset_count: got %0d/%0d expected 0", if0.char_count, if1.char_count); end
        checks++; if (if0.scroll_pos !== 3'd0) begin errors++; $display("FAIL midreset_pos: got %0d expected 0", if0.scroll_pos); end
        tick();
        rst = 1'b0;
        scroll_en = 1'b0;
    endtask

    task automatic test_show();
        put("A"); put("B"); put("C"); put("D");
        show = 1'b0;
        tick();
        checks++; if (if0.display !== 32'h41424344) begin errors++; $display("FAIL show_display: got %h expected 41424344", if0.display); end
        checks++; if (if0.char_count !== 4'd4) begin errors++; $display("FAIL show_count: got %0d expected 4", if0.char_count); end
        checks++; if (if0.full !== 1'b0) begin errors++; $display("FAIL show_full: got %b expected 0", if0.full); end
    endtask

    task automatic test_full();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 9; i++) put(8'(8'h41 + i));
        show = 1'b0;
        tick();
        checks++; if (if0.full !== 1'b1 || if1.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b/%b expected 1/1", if0.full, if1.full); end
        checks++; if (if0.char_count !== 4'd8 || if1.char_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d/%0d expected 8", if0.char_count, if1.char_count); end
        checks++; if (if0.display !== 32'h41424344) begin errors++; $display("FAIL full_drop_display: got %h expected 41424344", if0.display); end
        checks++; if (if1.display !== 32'h42434445) begin errors++; $display("FAIL full_overwrite_display: got %h expected 42434445", if1.display); end
    endtask

    task automatic test_scroll();
        scroll_en = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            checks++; if (if0.scroll_pos !== 3'((c / 3) % 8)) begin errors++; $display("FAIL scroll_pos cyc %0d: got %0d expected %0d", c, if0.scroll_pos, (c / 3) % 8); end
            if (c == 19) begin
                checks++; if (if0.display !== 32'h47484142) begin errors++; $display("FAIL scroll_ghab: got %h expected 47484142", if0.display); end
                checks++; if (if1.display !== 32'h48494243) begin errors++; $display("FAIL scroll_hibc: got %h expected 48494243", if1.display); end
            end
        end
        scroll_en = 1'b0;
        tick();
        checks++; if (if0.scroll_pos !== 3'd0 || if1.scroll_pos !== 3'd0) begin errors++; $display("FAIL scroll_stop: got %0d/%0d expected 0", if0.scroll_pos, if1.scroll_pos); end
    endtask

    task automatic test_clear();
        clear = 1'b1; show = 1'b1; char_in = "Z";
        tick();
        clear = 1'b0; show = 1'b0;
        checks++; if (if0.char_count !== 4'd0 || if1.char_count !== 4'd0) begin errors++; $display("FAIL clear_count: got %0d/%0d expected 0", if0.char_count, if1.char_count); end
        checks++; if (if0.full !== 1'b0 || if1.full !== 1'b0) begin errors++; $display("FAIL clear_full: got %b/%b expected 0", if0.full, if1.full); end
        tick();
        checks++; if (if0.display !== ALL_BLANK || if1.display !== ALL_BLANK) begin errors++; $display("FAIL clear_display: got %h/%h expected %h", if0.display, if1.display, ALL_BLANK); end
        put("Y");
        show = 1'b0;
        tick();
        checks++; if (if0.display !== 32'h59202020) begin errors++; $display("FAIL clear_z_dropped: got %h expected 59202020", if0.display); end
        checks++; if (if0.char_count !== 4'd1) begin errors++; $display("FAIL clear_then_show_count: got %0d expected 1", if0.char_count); end
    endtask

    task automatic test_partial();
        clear = 1'b1; tick(); clear = 1'b0;
        put("A"); put("B");
        show = 1'b0;
        scroll_en = 1'b1;
        repeat (4) tick();
        checks++; if (if0.scroll_pos !== 3'd1) begin errors++; $display("FAIL partial_pos: got %0d expected 1", if0.scroll_pos); end
        checks++; if (if0.display !== 32'h42202020) begin errors++; $display("FAIL partial_display: got %h expected 42202020", if0.display); end
        scroll_en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int c = 0; c < 600; c++) begin
            show      = ($urandom_range(0, 99) < 60);
            clear     = ($urandom_range(0, 99) < 3);
            scroll_en = ($urandom_range(0, 99) < 95);
            rst       = ($urandom_range(0, 199) == 0);
            char_in   = 8'($urandom_range(8'h41, 8'h5A));
            tick();
            checks++; if (if0.display !== exp_d0) begin errors++; $display("FAIL rand_display0 cyc %0d: got %h expected %h", c, if0.display, exp_d0); end
            checks++; if (if1.display !== exp_d1) begin errors++; $display("FAIL rand_display1 cyc %0d: got %h expected %h", c, if1.display, exp_d1); end
            checks++; if (if0.char_count !== 4'(q0.size()) || if1.char_count !== 4'(q1.size())) begin errors++; $display("FAIL rand_count cyc %0d: got %0d/%0d expected %0d/%0d", c, if0.char_count, if1.char_count, q0.size(), q1.size()); end
            checks++; if (if0.full !== (q0.size() == DEPTH) || if1.full !== (q1.size() == DEPTH)) begin errors++; $display("FAIL rand_full cyc %0d: got %b/%b", c, if0.full, if1.full); end
            checks++; if (if0.scroll_pos !== 3'(model_pos()) || if1.scroll_pos !== 3'(model_pos())) begin errors++; $display("FAIL rand_pos cyc %0d: got %0d/%0d expected %0d", c, if0.scroll_pos, if1.scroll_pos, model_pos()); end
        end
        rst = 1'b0; show = 1'b0; clear = 1'b0; scroll_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_show();
        test_full();
        test_scroll();
        test_clear();
        test_partial();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
